// File: rtl/udp_audio_pkg.sv
// Shared constants and types for the UDP audio packetizer.
//   HDR_BYTES   : payload header length (sequence number + sample count)
//   SEQ_W/CNT_W : widths of the sequence number and sample count fields
//   pkt_state_t : packet framing FSM states
package udp_audio_pkg;

   localparam int HDR_BYTES = 4;
   localparam int SEQ_W     = 16;
   localparam int CNT_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_SEQ_HI,
      ST_SEQ_LO,
      ST_CNT_HI,
      ST_CNT_LO,
      ST_DAT_HI,
      ST_DAT_LO
   } pkt_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_wr_en, i_wr_data  : write strobe and data (ignored when full unless popping)
//   i_rd_en             : pop the head entry (ignored when empty)
//   o_rd_data           : head entry, valid whenever !o_empty
//   o_rd_data_nxt       : entry behind the head, so a consumer can register it
//                         in the same cycle it pops the head
//   o_level, o_full, o_empty : occupancy
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic [WIDTH-1:0] o_rd_data_nxt,
   output logic [AW:0]      o_level,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic [AW-1:0]    w_rd_ptr_nxt;
   logic             w_wr;
   logic             w_rd;

   assign o_full        = (r_level == (AW+1)'(DEPTH));
   assign o_empty       = (r_level == '0);
   assign o_level       = r_level;
   // a pop frees the slot a simultaneous write lands in, so full+pop still writes
   assign w_wr          = i_wr_en && (!o_full || i_rd_en);
   assign w_rd          = i_rd_en && !o_empty;
   assign w_rd_ptr_nxt  = r_rd_ptr + 1'b1;
   assign o_rd_data     = r_mem[r_rd_ptr];
   assign o_rd_data_nxt = r_mem[w_rd_ptr_nxt];

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= w_rd_ptr_nxt;
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/udp_audio_packetizer.sv
// Buffers 16-bit audio samples and frames them into UDP payloads:
//   seq[15:8] seq[7:0] cnt[15:8] cnt[7:0] {data[15:8] data[7:0]} x cnt
// A partial packet is flushed after FLUSH_TIMEOUT idle cycles.
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_enable                    : allows new packets to start
//   i_sample_valid/data, o_sample_ready : sample input (drops counted, never stalled)
//   udp_tx_hdr_valid/ready      : per-packet header request
//   udp_tx_valid/ready/last/data: payload byte stream
//   o_drop_cnt                  : saturating count of dropped-sample cycles
//   o_pkt_cnt                   : completed packets (wraps)
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for a full packet or flush expiry
// ST_HDR    | header request held until accepted
// ST_SEQ_HI | sending sequence number, high byte
// ST_SEQ_LO | sending sequence number, low byte
// ST_CNT_HI | sending sample count, high byte
// ST_CNT_LO | sending sample count, low byte
// ST_DAT_HI | sending head sample, high byte
// ST_DAT_LO | sending head sample, low byte; pops on accept
module udp_audio_packetizer
   import udp_audio_pkg::*;
#(
   parameter int SAMPLES_PER_PKT = 64,
   parameter int FIFO_DEPTH      = 256,
   parameter int FLUSH_TIMEOUT   = 125000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic        i_sample_valid,
   input  logic [15:0] i_sample_data,
   output logic        o_sample_ready,
   output logic        udp_tx_hdr_valid,
   input  logic        udp_tx_hdr_ready,
   output logic        udp_tx_valid,
   input  logic        udp_tx_ready,
   output logic        udp_tx_last,
   output logic [7:0]  udp_tx_data,
   output logic [15:0] o_drop_cnt,
   output logic [15:0] o_pkt_cnt
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

   pkt_state_t       r_state, w_state_nxt;
   logic [LW-1:0]    w_level;
   logic             w_full, w_empty;
   logic [15:0]      w_head, w_head_nxt;
   logic             w_wr, w_pop, w_accept, w_start, w_lvl_ge, w_timer_run;
   logic [CNT_W-1:0] w_cnt_new;
   logic [SEQ_W-1:0] r_seq;
   logic [CNT_W-1:0] r_cnt, r_rem;
   logic [15:0]      r_pkt_cnt, r_drop_cnt;
   logic [TW-1:0]    r_timer;
   logic             r_expired;
   logic             r_hdr_valid, r_tx_valid, r_tx_last;
   logic [7:0]       r_tx_data;
   logic             w_hdr_valid_nxt, w_tx_valid_nxt, w_tx_last_nxt;
   logic [7:0]       w_data_nxt;

   sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_wr_en       (w_wr),
      .i_wr_data     (i_sample_data),
      .i_rd_en       (w_pop),
      .o_rd_data     (w_head),
      .o_rd_data_nxt (w_head_nxt),
      .o_level       (w_level),
      .o_full        (w_full),
      .o_empty       (w_empty)
   );

   assign w_accept       = r_tx_valid && udp_tx_ready;
   assign w_pop          = (r_state == ST_DAT_LO) && w_accept;
   // a pop at full frees a slot this cycle, so the sample is taken rather than dropped
   assign o_sample_ready = !w_full || w_pop;
   assign w_wr           = i_sample_valid && o_sample_ready;
   assign w_lvl_ge       = (w_level >= LW'(SAMPLES_PER_PKT));
   assign w_start        = (r_state == ST_IDLE) && i_enable &&
                           (w_lvl_ge || (r_expired && !w_empty));
   assign w_cnt_new      = w_lvl_ge ? CNT_W'(SAMPLES_PER_PKT) : CNT_W'(w_level);
   assign w_timer_run    = (r_state == ST_IDLE) && !w_empty && !w_lvl_ge;

   assign udp_tx_hdr_valid = r_hdr_valid;
   assign udp_tx_valid     = r_tx_valid;
   assign udp_tx_last      = r_tx_last;
   assign udp_tx_data      = r_tx_data;
   assign o_drop_cnt       = r_drop_cnt;
   assign o_pkt_cnt        = r_pkt_cnt;

   // outputs are registered, so the byte for the state being entered is chosen here
   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_tx_data;
      case (r_state)
         ST_IDLE:   if (w_start) w_state_nxt = ST_HDR;
         ST_HDR:    if (udp_tx_hdr_ready) begin
                       w_state_nxt = ST_SEQ_HI;
                       w_data_nxt  = r_seq[15:8];
                    end
         ST_SEQ_HI: if (w_accept) begin
                       w_state_nxt = ST_SEQ_LO;
                       w_data_nxt  = r_seq[7:0];
                    end
         ST_SEQ_LO: if (w_accept) begin
                       w_state_nxt = ST_CNT_HI;
                       w_data_nxt  = r_cnt[15:8];
                    end
         ST_CNT_HI: if (w_accept) begin
                       w_state_nxt = ST_CNT_LO;
                       w_data_nxt  = r_cnt[7:0];
                    end
         ST_CNT_LO: if (w_accept) begin
                       w_state_nxt = ST_DAT_HI;
                       w_data_nxt  = w_head[15:8];
                    end
         ST_DAT_HI: if (w_accept) begin
                       w_state_nxt = ST_DAT_LO;
                       w_data_nxt  = w_head[7:0];
                    end
         ST_DAT_LO: if (w_accept) begin
                       if (r_rem == CNT_W'(1)) begin
                          w_state_nxt = ST_IDLE;
                          w_data_nxt  = 8'h00;
                       end else begin
                          // head is being popped; the next sample sits behind it
                          w_state_nxt = ST_DAT_HI;
                          w_data_nxt  = w_head_nxt[15:8];
                       end
                    end
         default: begin
            w_state_nxt = ST_IDLE;
            w_data_nxt  = 8'h00;
         end
      endcase
      w_hdr_valid_nxt = (w_state_nxt == ST_HDR);
      w_tx_valid_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HDR);
      w_tx_last_nxt   = (w_state_nxt == ST_DAT_LO) && (r_rem == CNT_W'(1));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_hdr_valid <= 1'b0;
         r_tx_valid  <= 1'b0;
         r_tx_last   <= 1'b0;
         r_tx_data   <= 8'h00;
         r_seq       <= '0;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_pkt_cnt   <= '0;
         r_drop_cnt  <= '0;
         r_timer     <= '0;
         r_expired   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hdr_valid <= w_hdr_valid_nxt;
         r_tx_valid  <= w_tx_valid_nxt;
         r_tx_last   <= w_tx_last_nxt;
         r_tx_data   <= w_data_nxt;

         if (w_start) begin
            r_cnt <= w_cnt_new;
            r_rem <= w_cnt_new;
         end else if (w_pop) begin
            r_rem <= r_rem - 1'b1;
         end

         if (w_pop && (r_rem == CNT_W'(1))) begin
            r_seq     <= r_seq + 1'b1;
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
         end

         if (i_sample_valid && !o_sample_ready && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 1'b1;

         // expiry stays set until the packet it triggers actually starts
         if (w_start) begin
            r_timer   <= '0;
            r_expired <= 1'b0;
         end else if (w_timer_run) begin
            if (r_timer == TW'(FLUSH_TIMEOUT - 1)) r_expired <= 1'b1;
            else                                   r_timer   <= r_timer + 1'b1;
         end else begin
            r_timer <= '0;
         end
      end
   end

endmodule
